simple_sched: RTL and testbench

Round-robin scheduler that shares the single-bit NAND/NOR/negative-edge-flop datapath (`simple`) among `N_REQ` requesters. The datapath holds state in its flop (`n3`), so the scheduler drives a flush cycle before every grant. Within one burst it issues operand pairs back to back and returns each datapath result tagged with the requester ID. It sits directly in front of `simple` and drives its `inp1`/`inp2` pins.

---
 rtl/simple_sched_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/simple_sched.sv | 123 ++++++++++++
 tb/tb_simple_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_sched_pkg.sv
// Shared types and the round-robin pick helper for the simple_sched datapath scheduler.
package simple_sched_pkg;

  typedef enum logic [1:0] {StIdle, StFlush, StIssue} state_t;

  localparam int unsigned MAX_N_REQ = 8;
  localparam int unsigned IDX_W     = $clog2(MAX_N_REQ);

  // First set bit of valid strictly after last, wrapping. Unused high requesters must be zero,
  // which makes the mod-8 walk equivalent to a mod-N_REQ walk.
  function automatic logic [IDX_W-1:0] next_rr(input logic [MAX_N_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]     last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_N_REQ; i++) begin
      idx = last + IDX_W'(i);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester after the last grant.
module rr_arbiter
  import simple_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  grant_idx
);

  logic [MAX_N_REQ-1:0] valid_pad;
  logic [IDX_W-1:0]     pick;

  always_comb begin
    valid_pad              = '0;
    valid_pad[N_REQ-1:0]   = req_valid;
    pick                   = next_rr(valid_pad, IDX_W'(last));
  end

  assign any       = |req_valid;
  assign grant_idx = ID_W'(pick);

endmodule

// File: rtl/simple_sched.sv
// Round-robin burst scheduler in front of the single-bit NAND/NOR/negedge-flop datapath.
// Each grant starts with a flush cycle so the datapath flop begins every burst at zero.
module simple_sched
  import simple_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned ID_W      = $clog2(N_REQ)
) (
  input  logic             tau2015_clk,
  input  logic             tau2015_rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0] req_ready,
  output logic             resp_valid,
  output logic [ID_W-1:0]  resp_id,
  output logic             resp_data,
  output logic             dp_inp1,
  output logic             dp_inp2,
  input  logic             dp_out,
  output logic             busy
);

  localparam int unsigned         BEATS_W    = $clog2(MAX_BURST + 1);
  localparam logic [BEATS_W-1:0]  LAST_BEAT  = BEATS_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]     LAST_RESET = ID_W'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic               dp_inp1_q, dp_inp1_d;
  logic               dp_inp2_q, dp_inp2_d;
  logic               launch_valid_q;
  logic [ID_W-1:0]    launch_id_q;
  logic               resp_valid_q;
  logic [ID_W-1:0]    resp_id_q;
  logic               resp_data_q;
  logic               accept;
  logic               arb_any;
  logic [ID_W-1:0]    arb_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .last      (last_q),
    .any       (arb_any),
    .grant_idx (arb_idx)
  );

  // last_q doubles as the current grant once we leave IDLE.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    beats_d   = beats_q;
    req_ready = '0;
    accept    = 1'b0;
    dp_inp1_d = 1'b0;
    dp_inp2_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_any) begin
          last_d  = arb_idx;
          beats_d = '0;
          state_d = StFlush;
        end
      end
      StFlush: state_d = StIssue;
      StIssue: begin
        req_ready[last_q] = 1'b1;
        accept            = req_valid[last_q];
        if (accept) begin
          dp_inp1_d = req_a[last_q];
          dp_inp2_d = req_b[last_q];
          beats_d   = beats_q + 1'b1;
          if (beats_q == LAST_BEAT) state_d = StIdle;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge tau2015_clk or posedge tau2015_rst) begin
    if (tau2015_rst) begin
      state_q        <= StIdle;
      last_q         <= LAST_RESET;
      beats_q        <= '0;
      dp_inp1_q      <= 1'b0;
      dp_inp2_q      <= 1'b0;
      launch_valid_q <= 1'b0;
      launch_id_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_data_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      beats_q        <= beats_d;
      dp_inp1_q      <= dp_inp1_d;
      dp_inp2_q      <= dp_inp2_d;
      launch_valid_q <= accept;
      launch_id_q    <= last_q;
      // dp_out already reflects the falling-edge capture of the launched beat here.
      resp_valid_q   <= launch_valid_q;
      if (launch_valid_q) begin
        resp_id_q   <= launch_id_q;
        resp_data_q <= dp_out;
      end
    end
  end

  assign dp_inp1    = dp_inp1_q;
  assign dp_inp2    = dp_inp2_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_simple_sched.sv
// Scoreboard bench for simple_sched with a behavioural datapath and a burst-level reference model.
module tb_simple_sched;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned ID_W      = 2;

  typedef struct {
    int id;
    int data;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] req_valid = '0;
  logic [N_REQ-1:0] req_a = '0;
  logic [N_REQ-1:0] req_b = '0;
  logic [N_REQ-1:0] req_ready;
  logic             resp_valid, resp_data, dp_inp1, dp_inp2, busy;
  logic [ID_W-1:0]  resp_id;
  logic             dp_q = 1'b1;

  int errors = 0;
  int checks = 0;

  resp_t      exp_resp[$];
  int         exp_grant[$];
  int         lat_q[$];
  logic [1:0] beats_q[N_REQ][$];
  int         m_last = N_REQ - 1;
  int         grant_cnt = 0;
  int         seen_cnt = 0;
  int         cyc = 0;

  logic [N_REQ-1:0] acc_m = '0;
  logic [1:0]       acc_ab = '0;
  logic             prev_busy = 1'b0;
  logic             prev2_busy = 1'b0;
  logic [N_REQ-1:0] prev_ready = '0;

  simple_sched #(
    .N_REQ     (N_REQ),
    .MAX_BURST (MAX_BURST),
    .ID_W      (ID_W)
  ) dut (
    .tau2015_clk (clk),
    .tau2015_rst (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .dp_inp1     (dp_inp1),
    .dp_inp2     (dp_inp2),
    .dp_out      (dp_q),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Datapath model with no reset; q is forced to 1 at every grant so a missing flush shows up.
  always @(negedge clk) begin
    if (grant_cnt != seen_cnt) begin
      seen_cnt = grant_cnt;
      dp_q     = 1'b1;
    end
    dp_q = dp_inp1 & dp_inp2 & ~dp_q;
  end

  always @(negedge clk) begin
    acc_m  = req_valid & req_ready;
    acc_ab = 2'b00;
    for (int i = 0; i < N_REQ; i++) if (acc_m[i]) acc_ab = {req_a[i], req_b[i]};
  end

  // Monitor: launch register, one-hot ready, responses, grant order and flush gap.
  always @(posedge clk) begin
    resp_t e;
    int    g;
    #2;
    cyc++;
    if (rst) lat_q.delete();
    check("launch", int'({dp_inp1, dp_inp2}), (acc_m != '0) ? int'(acc_ab) : 0);
    if (acc_m != '0) lat_q.push_back(cyc);
    check("ready_onehot0", int'($onehot0(req_ready)), 1);
    if (resp_valid) begin
      if (exp_resp.size() == 0) begin
        check("resp_unexpected", int'(resp_valid), 0);
      end else begin
        e = exp_resp.pop_front();
        check("resp_id", int'(resp_id), e.id);
        check("resp_data", int'(resp_data), e.data);
      end
      if (lat_q.size() == 0) check("resp_without_accept", int'(resp_valid), 0);
      else check("resp_latency", cyc - lat_q.pop_front(), 1);
    end
    if (req_ready != '0 && prev_ready == '0) begin
      g = -1;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
      if (exp_grant.size() == 0) check("grant_unexpected", g, -1);
      else check("grant_id", g, exp_grant.pop_front());
      check("flush_gap", int'({prev2_busy, prev_busy}), 1);
    end
    if (busy && !prev_busy) grant_cnt++;
    prev2_busy = prev_busy;
    prev_busy  = busy;
    prev_ready = req_ready;
  end

  function automatic void drive();
    logic [1:0] b;
    for (int i = 0; i < N_REQ; i++) begin
      if (beats_q[i].size() != 0) begin
        b            = beats_q[i][0];
        req_valid[i] = 1'b1;
        req_a[i]     = b[1];
        req_b[i]     = b[0];
      end else begin
        req_valid[i] = 1'b0;
        req_a[i]     = 1'b0;
        req_b[i]     = 1'b0;
      end
    end
  endfunction

  // Burst-level model: round-robin over non-empty queues, up to MAX_BURST beats per grant,
  // datapath state zero at the start of every burst.
  task automatic plan();
    int         pos[N_REQ];
    int         g;
    int         q;
    logic [1:0] bt;
    for (int i = 0; i < N_REQ; i++) pos[i] = 0;
    forever begin
      g = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        int idx = (m_last + k) % N_REQ;
        if (g < 0 && pos[idx] < beats_q[idx].size()) g = idx;
      end
      if (g < 0) break;
      exp_grant.push_back(g);
      m_last = g;
      q      = 0;
      for (int n = 0; n < int'(MAX_BURST) && pos[g] < beats_q[g].size(); n++) begin
        bt = beats_q[g][pos[g]];
        pos[g]++;
        q = (bt == 2'b11 && q == 0) ? 1 : 0;
        exp_resp.push_back('{g, q});
      end
    end
  endtask

  task automatic step();
    logic [N_REQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++)
      if (acc[i] && beats_q[i].size() != 0) void'(beats_q[i].pop_front());
    drive();
    #2;
  endtask

  task automatic run_round(input string tag);
    bit done;
    done = 1'b0;
    drive();
    for (int c = 0; c < 400 && !done; c++) begin
      step();
      done = (exp_resp.size() == 0) && (exp_grant.size() == 0) && !busy;
      for (int i = 0; i < N_REQ; i++) if (beats_q[i].size() != 0) done = 1'b0;
    end
    check({"round_done_", tag}, int'(done), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ready"}, int'(req_ready), 0);
    check({tag, "_resp_valid"}, int'(resp_valid), 0);
    check({tag, "_resp_id"}, int'(resp_id), 0);
    check({tag, "_resp_data"}, int'(resp_data), 0);
    check({tag, "_dp_inp"}, int'({dp_inp1, dp_inp2}), 0);
  endtask

  task automatic push(input int r, input int n, input logic [1:0] b);
    for (int i = 0; i < n; i++) beats_q[r].push_back(b);
  endtask

  initial begin
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    // Only 2 and 3 valid right after reset: order 2, 3, 2.
    push(2, 6, 2'b11);
    push(3, 3, 2'b11);
    plan();
    run_round("rr_2_3");

    push(0, 2, 2'b11);
    push(0, 1, 2'b10);
    push(0, 1, 2'b11);
    plan();
    run_round("single_0");

    push(0, 8, 2'b11);
    push(1, 8, 2'b11);
    plan();
    run_round("alt_0_1");

    push(1, 1, 2'b11);
    push(0, 2, 2'b11);
    plan();
    run_round("drop_1");

    // Reset with a beat in flight.
    push(1, 4, 2'b11);
    plan();
    drive();
    for (int c = 0; c < 20 && lat_q.size() == 0; c++) step();
    check("inflight_seen", int'(lat_q.size() != 0), 1);
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    for (int i = 0; i < N_REQ; i++) beats_q[i].delete();
    exp_resp.delete();
    exp_grant.delete();
    m_last = N_REQ - 1;
    drive();
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) push(i, 2, 2'b11);
    plan();
    run_round("after_reset");

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(1, 0) == 1) begin
          int len = $urandom_range(2 * MAX_BURST + 1, 1);
          for (int k = 0; k < len; k++) begin
            logic [1:0] b;
            b[1] = ($urandom_range(3, 0) != 0);
            b[0] = ($urandom_range(3, 0) != 0);
            beats_q[i].push_back(b);
          end
        end
      end
      plan();
      run_round("random");
    end

    check("leftover_resp", exp_resp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
